// File: rtl/tone_pkg.sv
// Shared constants and types for the tone-generator datapath and its write scheduler.
package tone_pkg;

  localparam int unsigned COUNT_WIDTH = 10;
  localparam int unsigned FRAME_LEN   = 1024;
  localparam int unsigned ADDR_WIDTH  = 4;
  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;

  // Datapath finishes phase update and mixing at this master count.
  localparam int unsigned LAST_MIX_COUNT = 11;
  localparam int unsigned DEF_WIN_START  = LAST_MIX_COUNT + 1;
  localparam int unsigned DEF_WIN_END    = FRAME_LEN - 2;

  typedef enum logic [1:0] {
    ADDR_SEL_INCR = 2'h0,
    ADDR_SEL_VOL  = 2'h1,
    ADDR_SEL_WAVE = 2'h2,
    ADDR_SEL_BAD  = 2'h3
  } addr_sel_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_entry_t;

  function automatic logic addr_is_legal(input logic [ADDR_WIDTH-1:0] addr);
    return addr_sel_e'(addr[3:2]) != ADDR_SEL_BAD;
  endfunction

endpackage

// File: rtl/write_fifo.sv
// Synchronous FIFO; full/empty distinguished by an extra wrap bit on each pointer.
module write_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 20,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/tone_write_scheduler.sv
// Master frame counter plus a queued host-write path that only releases register
// writes to the tone datapath inside the safe window of each frame.
module tone_write_scheduler
  import tone_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIN_START  = DEF_WIN_START,
  parameter int unsigned WIN_END    = DEF_WIN_END
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [ADDR_WIDTH-1:0]  host_addr_in,
  input  logic [DATA_WIDTH-1:0]  host_data_in,
  input  logic                   host_valid_in,
  output logic                   host_ready_out,
  output logic [COUNT_WIDTH-1:0] master_count_out,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid_out,
  output logic [2:0]             pending_out,
  output logic                   err_out
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [COUNT_WIDTH-1:0] WS = COUNT_WIDTH'(WIN_START);
  localparam logic [COUNT_WIDTH-1:0] WE = COUNT_WIDTH'(WIN_END);

  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_next;
  logic                   in_win_next;
  logic                   accept;
  logic                   legal;
  logic                   bypass;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          pend_next;
  logic                   ready_q;
  logic                   valid_q;
  logic                   err_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  wr_entry_t              wr_entry;
  wr_entry_t              head;

  // Output registers load on the edge entering an in-window count, so an
  // issue decision looks at the next count and at the pre-edge queue state.
  always_comb begin
    cnt_next    = cnt_q + 1'b1;
    in_win_next = (cnt_next >= WS) && (cnt_next <= WE);
    accept      = host_valid_in && ready_q;
    legal       = addr_is_legal(host_addr_in);
    fifo_pop    = in_win_next && !fifo_empty;
    bypass      = in_win_next && fifo_empty && accept && legal;
    fifo_push   = accept && legal && !bypass;
    pend_next   = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    wr_entry    = '{addr: host_addr_in, data: host_data_in};
  end

  write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .wr_data  (wr_entry),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      cnt_q <= cnt_next;
      // Ready drops as soon as the queue fills but returns one cycle after the freeing pop.
      ready_q <= (pend_next != CW'(FIFO_DEPTH)) && !fifo_full;
      if (accept && !legal)
        err_q <= 1'b1;
      if (fifo_pop) begin
        valid_q <= 1'b1;
        addr_q  <= head.addr;
        data_q  <= head.data;
      end else if (bypass) begin
        valid_q <= 1'b1;
        addr_q  <= host_addr_in;
        data_q  <= host_data_in;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign host_ready_out   = ready_q;
  assign master_count_out = cnt_q;
  assign addr_out         = addr_q;
  assign data_out         = data_q;
  assign data_valid_out   = valid_q;
  assign pending_out      = 3'(fifo_count);
  assign err_out          = err_q;

endmodule

// File: tb/tb_tone_write_scheduler.sv
// Directed self-checking bench for tone_write_scheduler with default parameters.
module tb_tone_write_scheduler;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [3:0]  host_addr_in;
  logic [15:0] host_data_in;
  logic        host_valid_in;
  logic        host_ready_out;
  logic [9:0]  master_count_out;
  logic [3:0]  addr_out;
  logic [15:0] data_out;
  logic        data_valid_out;
  logic [2:0]  pending_out;
  logic        err_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cnt;
    logic [3:0]  a;
    logic [15:0] d;
  } pulse_t;
  pulse_t pq[$];

  tone_write_scheduler dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .host_addr_in     (host_addr_in),
    .host_data_in     (host_data_in),
    .host_valid_in    (host_valid_in),
    .host_ready_out   (host_ready_out),
    .master_count_out (master_count_out),
    .addr_out         (addr_out),
    .data_out         (data_out),
    .data_valid_out   (data_valid_out),
    .pending_out      (pending_out),
    .err_out          (err_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (data_valid_out)
      pq.push_back('{cnt: int'(master_count_out), a: addr_out, d: data_out});
  end

  task automatic wait_cnt(input int n);
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk_in);
      if (int'(master_count_out) == n) return;
    end
    checks++; errors++;
    $display("FAIL wait_cnt: count %0d never reached (now %0d)", n, master_count_out);
  endtask

  task automatic push(input logic [3:0] a, input logic [15:0] d);
    host_addr_in  = a;
    host_data_in  = d;
    host_valid_in = 1'b1;
    @(posedge clk_in);
    #1 host_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    checks++; if (master_count_out !== 10'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", master_count_out); end
    checks++; if (host_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", host_ready_out); end
    checks++; if (pending_out !== 3'd0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pending_out); end
    checks++; if (data_valid_out !== 1'b0 || err_out !== 1'b0) begin errors++; $display("FAIL reset_valid_err: got %b/%b expected 0/0", data_valid_out, err_out); end
    @(negedge clk_in);
    checks++; if (master_count_out !== 10'd1) begin errors++; $display("FAIL count_after_reset: got %0d expected 1", master_count_out); end
    @(negedge clk_in);
    push(4'h1, 16'h1111);
    push(4'h2, 16'h2222);
    @(negedge clk_in);
    checks++; if (pending_out !== 3'd2) begin errors++; $display("FAIL pending_before_reset: got %0d expected 2", pending_out); end
    #2 reset_in = 1'b1;
    #1;
    checks++; if (master_count_out !== 10'd0 || pending_out !== 3'd0) begin errors++; $display("FAIL async_reset_clear: count %0d pending %0d expected 0 0", master_count_out, pending_out); end
    checks++; if (data_valid_out !== 1'b0 || addr_out !== 4'h0 || data_out !== 16'h0 || err_out !== 1'b0) begin errors++; $display("FAIL async_reset_outputs: v %b a %h d %h e %b expected all 0", data_valid_out, addr_out, data_out, err_out); end
    @(negedge clk_in);
    reset_in = 1'b0;
    checks++; if (host_ready_out !== 1'b1 || pending_out !== 3'd0) begin errors++; $display("FAIL release_ready_pending: got %b/%0d expected 1/0", host_ready_out, pending_out); end
    @(negedge clk_in);
    checks++; if (master_count_out !== 10'd1) begin errors++; $display("FAIL release_count1: got %0d expected 1", master_count_out); end
    @(negedge clk_in);
    checks++; if (master_count_out !== 10'd2) begin errors++; $display("FAIL release_count2: got %0d expected 2", master_count_out); end
    #1 pq.delete();
    wait_cnt(20);
    #1;
    checks++; if (pq.size() != 0) begin errors++; $display("FAIL lost_writes_issued: got %0d pulses expected 0", pq.size()); end
  endtask

  task automatic test_single_write();
    wait_cnt(5);
    #1 pq.delete();
    push(4'h0, 16'h1234);
    @(negedge clk_in);
    checks++; if (pending_out !== 3'd1) begin errors++; $display("FAIL single_pending1: got %0d expected 1", pending_out); end
    wait_cnt(13);
    #1;
    checks++; if (pq.size() != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", pq.size()); end
    else begin
      checks++; if (pq[0].cnt != 12 || pq[0].a !== 4'h0 || pq[0].d !== 16'h1234) begin errors++; $display("FAIL single_issue: got cnt %0d a %h d %h expected 12 0 1234", pq[0].cnt, pq[0].a, pq[0].d); end
    end
    checks++; if (pending_out !== 3'd0) begin errors++; $display("FAIL single_pending0: got %0d expected 0", pending_out); end
  endtask

  task automatic test_window_edge();
    wait_cnt(100);
    #1 pq.delete();
    push(4'h5, 16'h00C0);
    wait_cnt(102);
    #1;
    checks++; if (pq.size() != 1) begin errors++; $display("FAIL fast_pulses: got %0d expected 1", pq.size()); end
    else begin
      checks++; if (pq[0].cnt != 101 || pq[0].a !== 4'h5 || pq[0].d !== 16'h00C0) begin errors++; $display("FAIL fast_issue: got cnt %0d a %h d %h expected 101 5 00c0", pq[0].cnt, pq[0].a, pq[0].d); end
    end
    pq.delete();
    wait_cnt(1022);
    push(4'h9, 16'hBEEF);
    @(negedge clk_in);
    checks++; if (pending_out !== 3'd1 || data_valid_out !== 1'b0) begin errors++; $display("FAIL edge_1023: pending %0d valid %b expected 1 0", pending_out, data_valid_out); end
    wait_cnt(5);
    checks++; if (addr_out !== 4'h5 || data_out !== 16'h00C0) begin errors++; $display("FAIL hold_outputs: got a %h d %h expected 5 00c0", addr_out, data_out); end
    wait_cnt(13);
    #1;
    checks++; if (pq.size() != 1) begin errors++; $display("FAIL edge_pulses: got %0d expected 1", pq.size()); end
    else begin
      checks++; if (pq[0].cnt != 12 || pq[0].a !== 4'h9 || pq[0].d !== 16'hBEEF) begin errors++; $display("FAIL edge_issue: got cnt %0d a %h d %h expected 12 9 beef", pq[0].cnt, pq[0].a, pq[0].d); end
    end
  endtask

  task automatic test_full_stall();
    int first_ready;
    logic [3:0]  exp_a [5];
    logic [15:0] exp_d [5];
    wait_cnt(0);
    #1 pq.delete();
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = 4'(i);
      exp_d[i] = 16'hA000 + 16'(i);
      push(exp_a[i], exp_d[i]);
    end
    exp_a[4] = 4'h7;
    exp_d[4] = 16'hA004;
    @(negedge clk_in);
    checks++; if (host_ready_out !== 1'b0 || pending_out !== 3'd4) begin errors++; $display("FAIL full_state: ready %b pending %0d expected 0 4", host_ready_out, pending_out); end
    host_addr_in  = exp_a[4];
    host_data_in  = exp_d[4];
    host_valid_in = 1'b1;
    first_ready = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (host_ready_out === 1'b1) begin
        first_ready = int'(master_count_out);
        break;
      end
    end
    @(posedge clk_in);
    #1 host_valid_in = 1'b0;
    checks++; if (first_ready != 13) begin errors++; $display("FAIL ready_return: got count %0d expected 13", first_ready); end
    wait_cnt(17);
    #1;
    checks++; if (pq.size() != 5) begin errors++; $display("FAIL full_pulses: got %0d expected 5", pq.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pq[i].cnt != 12 + i || pq[i].a !== exp_a[i] || pq[i].d !== exp_d[i]) begin
          errors++;
          $display("FAIL full_order[%0d]: got cnt %0d a %h d %h expected %0d %h %h", i, pq[i].cnt, pq[i].a, pq[i].d, 12 + i, exp_a[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_illegal_addr();
    wait_cnt(30);
    #1 pq.delete();
    checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL err_initial: got %b expected 0", err_out); end
    push(4'hD, 16'h5555);
    @(negedge clk_in);
    checks++; if (err_out !== 1'b1 || pending_out !== 3'd0 || data_valid_out !== 1'b0) begin errors++; $display("FAIL illegal_reject: err %b pending %0d valid %b expected 1 0 0", err_out, pending_out, data_valid_out); end
    push(4'h2, 16'h7777);
    wait_cnt(40);
    #1;
    checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_out); end
    checks++; if (pq.size() != 1) begin errors++; $display("FAIL illegal_pulses: got %0d expected 1", pq.size()); end
    else begin
      checks++; if (pq[0].cnt != 32 || pq[0].a !== 4'h2 || pq[0].d !== 16'h7777) begin errors++; $display("FAIL legal_after_err: got cnt %0d a %h d %h expected 32 2 7777", pq[0].cnt, pq[0].a, pq[0].d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_a [21];
    logic [15:0] exp_d [21];
    wait_cnt(20);
    #1 pq.delete();
    for (int i = 0; i < 21; i++) begin
      exp_a[i] = {2'(i % 3), 2'(i % 4)};
      exp_d[i] = 16'h6000 + 16'(i * 7);
      push(exp_a[i], exp_d[i]);
      checks++;
      if (pending_out !== 3'd0 || host_ready_out !== 1'b1) begin
        errors++;
        $display("FAIL b2b_pending[%0d]: pending %0d ready %b expected 0 1", i, pending_out, host_ready_out);
      end
    end
    wait_cnt(45);
    #1;
    checks++; if (pq.size() != 21) begin errors++; $display("FAIL b2b_pulses: got %0d expected 21", pq.size()); end
    else begin
      for (int i = 0; i < 21; i++) begin
        checks++;
        if (pq[i].cnt != 21 + i || pq[i].a !== exp_a[i] || pq[i].d !== exp_d[i]) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got cnt %0d a %h d %h expected %0d %h %h", i, pq[i].cnt, pq[i].a, pq[i].d, 21 + i, exp_a[i], exp_d[i]);
        end
      end
    end
  endtask

  initial begin
    reset_in      = 1'b1;
    host_addr_in  = '0;
    host_data_in  = '0;
    host_valid_in = 1'b0;
    test_reset();
    test_single_write();
    test_window_edge();
    test_full_stall();
    test_illegal_addr();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
